ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register. It consumes the latched operand values and an M-extension funct3 selector. It computes the result with a radix-2 shift-add/shift-subtract datapath and holds the pipeline via `stall` until the result is ready. All eight RV32M operations have the same fixed latency, so stall behaviour is deterministic.

---
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv.sv | 193 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_if
// Brief    : Request/response bundle between the EX stage and the RV32M unit.
// Revision : 1.0
// ============================================================================
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            kill;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_val, rs2_val, kill,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, kill,
        output busy, stall, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative radix-2 RV32M multiply/divide, fixed 33-cycle latency.
// Revision : 1.0
// ============================================================================
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_if.slave    bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_MUL    = 3'b000;
    localparam logic [2:0] c_MULH   = 3'b001;
    localparam logic [2:0] c_MULHSU = 3'b010;
    localparam logic [2:0] c_MULHU  = 3'b011;
    localparam logic [2:0] c_DIV    = 3'b100;
    localparam logic [2:0] c_DIVU   = 3'b101;
    localparam logic [2:0] c_REM    = 3'b110;
    localparam logic [2:0] c_REMU   = 3'b111;

    localparam int                c_CW   = $clog2(XLEN);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   c_ONES = {XLEN{1'b1}};

    logic [1:0]        r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_origA;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic              r_div0;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // ---------------- accept-time operand conditioning ----------------
    logic            w_aSigned;
    logic            w_bSigned;
    logic            w_sA;
    logic            w_sB;
    logic [XLEN-1:0] w_magA;
    logic [XLEN-1:0] w_magB;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic            w_accept;

    assign w_aSigned = (bus.op == c_MULH) || (bus.op == c_MULHSU) ||
                       (bus.op == c_DIV)  || (bus.op == c_REM);
    assign w_bSigned = (bus.op == c_MULH) || (bus.op == c_DIV) || (bus.op == c_REM);
    assign w_sA      = w_aSigned & bus.rs1_val[XLEN-1];
    assign w_sB      = w_bSigned & bus.rs2_val[XLEN-1];
    assign w_magA    = w_sA ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
    assign w_magB    = w_sB ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
    // Remainder follows the dividend sign; everything else is sA^sB.
    assign w_neg     = (bus.op == c_REM) ? w_sA : (w_sA ^ w_sB);
    assign w_div0    = (bus.rs2_val == {XLEN{1'b0}});
    assign w_ovf     = ((bus.op == c_DIV) || (bus.op == c_REM)) &&
                       (bus.rs1_val == c_MIN) && (bus.rs2_val == c_ONES);
    assign w_accept  = (r_state == c_IDLE) && bus.start && !bus.kill;

    // ---------------- one iteration of the datapath ----------------
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_mulSum;
    logic [2*XLEN-1:0] w_mulNext;
    logic [XLEN:0]     w_divTrial;
    logic [XLEN:0]     w_divDiff;
    logic              w_divOk;
    logic [XLEN-1:0]   w_divRem;
    logic [2*XLEN-1:0] w_divNext;
    logic [2*XLEN-1:0] w_accNext;

    assign w_addend  = r_b[0] ? r_a : {XLEN{1'b0}};
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

    // Dividend bits enter MSB-first from r_a; quotient bits fill acc from the LSB.
    assign w_divTrial = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    assign w_divDiff  = w_divTrial - {1'b0, r_b};
    assign w_divOk    = ~w_divDiff[XLEN];
    assign w_divRem   = w_divOk ? w_divDiff[XLEN-1:0] : w_divTrial[XLEN-1:0];
    assign w_divNext  = {w_divRem, r_acc[XLEN-2:0], w_divOk};

    assign w_accNext  = r_op[2] ? w_divNext : w_mulNext;

    // ---------------- result formation on the final iteration ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_divField;
    logic [XLEN-1:0]   w_divSigned;
    logic [XLEN-1:0]   w_result;

    assign w_prod      = r_neg ? (~w_accNext + 1'b1) : w_accNext;
    assign w_divField  = r_op[1] ? w_accNext[2*XLEN-1:XLEN] : w_accNext[XLEN-1:0];
    assign w_divSigned = r_neg ? (~w_divField + 1'b1) : w_divField;

    always_comb begin
        w_result = w_prod[XLEN-1:0];
        case (r_op)
            c_MUL:                    w_result = w_prod[XLEN-1:0];
            c_MULH, c_MULHSU, c_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            c_DIV, c_DIVU: begin
                if (r_div0)     w_result = c_ONES;
                else if (r_ovf) w_result = c_MIN;
                else            w_result = w_divSigned;
            end
            c_REM, c_REMU: begin
                if (r_div0)     w_result = r_origA;
                else if (r_ovf) w_result = {XLEN{1'b0}};
                else            w_result = w_divSigned;
            end
            default:                  w_result = w_prod[XLEN-1:0];
        endcase
    end

    // ---------------- control and state ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= {c_CW{1'b0}};
            r_op     <= 3'b000;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_origA  <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_CALC;
                        r_busy  <= 1'b1;
                        r_op    <= bus.op;
                        r_a     <= w_magA;
                        r_b     <= w_magB;
                        r_origA <= bus.rs1_val;
                        r_neg   <= w_neg;
                        r_div0  <= w_div0;
                        r_ovf   <= w_ovf;
                        r_acc   <= {(2*XLEN){1'b0}};
                        r_cnt   <= {c_CW{1'b0}};
                    end
                end
                c_CALC: begin
                    if (bus.kill) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_accNext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op[2]) r_a <= r_a << 1;
                        else         r_b <= r_b >> 1;
                        if (r_cnt == c_LAST) begin
                            r_state  <= c_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_result;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    // Low in DONE so the pipe advances in the same cycle the result strobes.
    assign bus.stall  = w_accept || (r_state == c_CALC);
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Self-checking bench for ex_muldiv against a behavioural RV32M model.
// Revision : 1.0
// ============================================================================
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();
    ex_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    bit cmpEn  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M result, straight from the ISA definition.
    function automatic logic [31:0] refOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, ua, ub, p;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = ea * eb; return p[63:32]; end
            3'd2: begin p = ea * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Timing model: phase 0 idle, 1..32 computing, 33 result strobe.
    int          mPhase   = 0;
    logic [31:0] mResult  = 32'd0;
    logic [31:0] mPending = 32'd0;

    always @(posedge clk) begin
        if (!rst) begin
            mPhase  = 0;
            mResult = 32'd0;
        end else if (mPhase == 0) begin
            if (bus.start && !bus.kill) begin
                mPhase   = 1;
                mPending = refOp(bus.op, bus.rs1_val, bus.rs2_val);
            end
        end else if (mPhase <= 32) begin
            if (bus.kill) mPhase = 0;
            else begin
                mPhase = mPhase + 1;
                if (mPhase == 33) mResult = mPending;
            end
        end else begin
            mPhase = 0;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            logic expBusy;
            expBusy = (mPhase >= 1) && (mPhase <= 32);
            chk("cyc_busy",   {31'd0, bus.busy},  {31'd0, expBusy});
            chk("cyc_done",   {31'd0, bus.done},  {31'd0, mPhase == 33});
            chk("cyc_stall",  {31'd0, bus.stall},
                {31'd0, expBusy || (mPhase == 0 && bus.start && !bus.kill)});
            chk("cyc_result", bus.result, mResult);
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.start   = 1'b1;
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1'b1; break; end
            @(posedge clk);
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one op, measure latency and stall length, check the literal result.
    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int  cycles, stallCnt;
        bit  seen;
        cycles = 0; stallCnt = 0; seen = 1'b0;
        @(posedge clk); #1;
        drive(op, a, b);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.stall) stallCnt++;
            if (bus.done) begin seen = 1'b1; break; end
            @(posedge clk);
            cycles++;
            #1 bus.start = 1'b0;
        end
        bus.start = 1'b0;
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
        chk(name, bus.result, exp);
        chk({name, "_latency"}, 32'(cycles), 32'd33);
        chk({name, "_stall"},   32'(stallCnt), 32'd33);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          doneCnt;

        rst = 1'b0;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0;
        bus.rs1_val = 32'd0; bus.rs2_val = 32'd0;
        repeat (3) @(posedge clk);
        cmpEn = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_busy",   {31'd0, bus.busy}, 32'd0);
        chk("reset_done",   {31'd0, bus.done}, 32'd0);
        chk("reset_result", bus.result,        32'd0);

        runOp("mul_neg",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runOp("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("mulh_m1",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        runOp("mulhsu",      3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        runOp("div_neg",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        runOp("rem_neg",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        runOp("divu",        3'd5, 32'd100,        32'd7,         32'd14);
        runOp("divu_zero",   3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
        runOp("rem_zero",    3'd6, 32'h1234,       32'd0,         32'h1234);
        runOp("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        runOp("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        runOp("remu",        3'd7, 32'd100,        32'd7,         32'd2);

        // Kill on CALC cycle 10: no strobe, result keeps the REMU value.
        @(posedge clk); #1 drive(3'd0, 32'd5, 32'd6);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk); #1 bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_busy",  {31'd0, bus.busy},  32'd0);
        chk("kill_stall", {31'd0, bus.stall}, 32'd0);
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        chk("kill_nodone", 32'(doneCnt), 32'd0);
        chk("kill_result", bus.result, 32'd2);
        runOp("divu_after_kill", 3'd5, 32'd9, 32'd3, 32'd3);

        // Reset on CALC cycle 5 of a DIV.
        @(posedge clk); #1 drive(3'd4, 32'd100, 32'hFFFF_FFFD);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_result", bus.result,        32'd0);

        // start+kill together in IDLE must not accept.
        @(posedge clk); #1 drive(3'd5, 32'd50, 32'd5); bus.kill = 1'b1;
        @(negedge clk);
        chk("startkill_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1 bus.start = 1'b0; bus.kill = 1'b0;
        @(negedge clk);
        chk("startkill_busy", {31'd0, bus.busy}, 32'd0);

        // start held through DONE is ignored; the next accept is a cycle later.
        @(posedge clk); #1 drive(3'd5, 32'd100, 32'd7);
        waitDone("hold1");
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_idle_busy",  {31'd0, bus.busy},  32'd0);
        chk("hold_idle_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("hold_reaccept", {31'd0, bus.busy}, 32'd1);
        waitDone("hold2");
        chk("hold_result", bus.result, 32'd14);

        // Randomized ops, occasional kills and gaps; the cycle compare does the work.
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pickVal();
            rb  = pickVal();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1 drive(rop, ra, rb);
                @(posedge clk); #1 bus.start = 1'b0;
                repeat ($urandom_range(0, 30)) @(posedge clk);
                #1 bus.kill = 1'b1;
                @(posedge clk); #1 bus.kill = 1'b0;
            end else begin
                runOp("rand", rop, ra, rb, refOp(rop, ra, rb));
            end
        end

        repeat (3) @(posedge clk);
        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
